// File: rtl/mcycle_pkg.sv
// Shared constants for the multi-cycle multiply/divide engine: FSM encoding and op codes.
package mcycle_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic MCYCLE_OP_MUL = 1'b0;
   localparam logic MCYCLE_OP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply (LSB-first shift-add) / divide (MSB-first restoring), one bit per cycle.
// A single hi/lo register pair serves both ops: product accumulator or partial remainder / quotient.
module mcycle_unit
   import mcycle_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cond_ex,
   input  logic             mcycle_op,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic [WIDTH-1:0] result1,
   output logic [WIDTH-1:0] result2,
   output logic             busy,
   output logic             done
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic             op_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg, opb_reg;
   logic [WIDTH-1:0] result1_reg, result2_reg;

   logic             accept, last_iter;
   logic [WIDTH:0]   sum, addend, shifted;
   logic [WIDTH-1:0] diff;
   logic             rem_ge;
   logic [WIDTH-1:0] hi_next, lo_next;

   assign accept    = rst_n && (state_reg == S_IDLE) && start && cond_ex && !flush;
   assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

   // One iteration of either algorithm, computed from the current hi/lo pair.
   always_comb begin
      sum     = {1'b0, hi_reg} + {1'b0, opb_reg};
      addend  = lo_reg[0] ? sum : {1'b0, hi_reg};
      shifted = {hi_reg, lo_reg[WIDTH-1]};
      rem_ge  = (shifted >= {1'b0, opb_reg});
      // Only used when rem_ge, where the true difference is below the divisor and fits WIDTH bits.
      diff    = shifted[WIDTH-1:0] - opb_reg;
      hi_next = hi_reg;
      lo_next = lo_reg;
      if (op_reg == MCYCLE_OP_MUL) begin
         hi_next = addend[WIDTH:1];
         lo_next = {addend[0], lo_reg[WIDTH-1:1]};
      end else begin
         hi_next = rem_ge ? diff : shifted[WIDTH-1:0];
         lo_next = {lo_reg[WIDTH-2:0], rem_ge};
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               busy       = 1'b1;
               state_next = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            busy = 1'b1;
            if (flush)
               state_next = S_IDLE;
            else if (last_iter)
               state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         op_reg      <= MCYCLE_OP_MUL;
         hi_reg      <= '0;
         lo_reg      <= '0;
         opb_reg     <= '0;
         result1_reg <= '0;
         result2_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  op_reg  <= mcycle_op;
                  cnt_reg <= '0;
                  hi_reg  <= '0;
                  // lo shifts the multiplier out (mul) or the dividend out / quotient in (div)
                  lo_reg  <= (mcycle_op == MCYCLE_OP_DIV) ? operand1 : operand2;
                  opb_reg <= (mcycle_op == MCYCLE_OP_DIV) ? operand2 : operand1;
               end
            end
            S_COMPUTE: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               hi_reg  <= hi_next;
               lo_reg  <= lo_next;
               if (last_iter && !flush) begin
                  result1_reg <= lo_next;
                  result2_reg <= hi_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign result1 = result1_reg;
   assign result2 = result2_reg;

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed table, hand-written corner sequences, random ops vs a model.
module tb_mcycle_unit;
   import mcycle_pkg::*;

   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst_n, start, cond_ex, mcycle_op, flush;
   logic [WIDTH-1:0] operand1, operand2, result1, result2;
   logic             busy, done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;   // {result2, result1}
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   mcycle_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cond_ex(cond_ex),
      .mcycle_op(mcycle_op), .flush(flush), .operand1(operand1), .operand2(operand2),
      .result1(result1), .result2(result2), .busy(busy), .done(done)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic; divide by zero gives all-ones quotient and the dividend as remainder.
   function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
      if (op == MCYCLE_OP_MUL)
         return {32'd0, a} * {32'd0, b};
      else if (b == 32'd0)
         return {a, 32'hFFFF_FFFF};
      else
         return {a % b, a / b};
   endfunction

   // Accept an op: checks combinational busy in cycle 0, returns #1 into cycle 1 with inputs scrambled.
   task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; cond_ex = 1'b1; mcycle_op = op; operand1 = a; operand2 = b;
      @(negedge clk);
      check("busy_accept_cycle", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      start = 1'b0; mcycle_op = ~op; operand1 = $urandom; operand2 = $urandom;
   endtask

   task automatic wait_done(output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = 0;
      for (int c = 1; c <= LAT + 8; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
      int lat, bc;
      launch(op, a, b);
      wait_done(lat, bc);
      $display("op=%0d a=%h b=%h -> r2=%h r1=%h lat=%0d", op, a, b, result2, result1, lat);
      check("latency", 64'(lat), 64'(LAT));
      check("busy_compute_cycles", 64'(bc), 64'(WIDTH));
      check("result", {result2, result1}, exp);
      @(negedge clk);
      check("done_one_cycle", {62'd0, busy, done}, 64'd0);
   endtask

   // Hold start for a while with acceptance blocked; nothing may happen.
   task automatic blocked_start(input logic ce, input logic fl, input string name);
      logic [63:0] saved;
      int bc, dc;
      saved = {result2, result1};
      bc = 0; dc = 0;
      @(posedge clk); #1;
      start = 1'b1; cond_ex = ce; flush = fl; mcycle_op = MCYCLE_OP_MUL;
      operand1 = 32'd9; operand2 = 32'd9;
      for (int c = 0; c < LAT + 5; c++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done) dc++;
      end
      start = 1'b0; cond_ex = 1'b1; flush = 1'b0;
      $display("blocked start %s: busy_cycles=%0d done_pulses=%0d", name, bc, dc);
      check({name, "_busy"}, 64'(bc), 64'd0);
      check({name, "_done"}, 64'(dc), 64'd0);
      check({name, "_results"}, {result2, result1}, saved);
   endtask

   initial begin
      logic [63:0] saved;
      int          dc;
      logic        rop;
      logic [31:0] ra, rb;

      vecs[0] = '{MCYCLE_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[1] = '{MCYCLE_OP_DIV, 32'd100,       32'd7,         {32'd2, 32'd14}};
      vecs[2] = '{MCYCLE_OP_DIV, 32'h1234,      32'd0,         {32'h1234, 32'hFFFF_FFFF}};
      vecs[3] = '{MCYCLE_OP_MUL, 32'd3,         32'd5,         64'd15};
      vecs[4] = '{MCYCLE_OP_DIV, 32'd7,         32'd100,       {32'd7, 32'd0}};
      vecs[5] = '{MCYCLE_OP_DIV, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF}};
      vecs[6] = '{MCYCLE_OP_MUL, 32'd0,         32'hFFFF_FFFF, 64'd0};
      vecs[7] = '{MCYCLE_OP_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1}};
      vecs[8] = '{MCYCLE_OP_MUL, 32'h8000_0000, 32'd2,         64'h1_0000_0000};
      vecs[9] = '{MCYCLE_OP_DIV, 32'd0,         32'd5,         64'd0};

      rst_n = 1'b0; start = 1'b0; cond_ex = 1'b0; mcycle_op = 1'b0; flush = 1'b0;
      operand1 = '0; operand2 = '0;
      repeat (3) @(negedge clk);
      check("reset_results", {result2, result1}, 64'd0);
      check("reset_busy_done", {62'd0, busy, done}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Results persist in IDLE
      run_op(MCYCLE_OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14});
      repeat (10) @(negedge clk);
      check("hold_in_idle", {result2, result1}, {32'd2, 32'd14});

      blocked_start(1'b0, 1'b0, "cond_ex_low");
      blocked_start(1'b1, 1'b1, "flush_in_idle");

      // start pulse during COMPUTE is dropped: exactly one done, original operands
      launch(MCYCLE_OP_MUL, 32'd6, 32'd7);
      repeat (4) @(posedge clk);
      #1; start = 1'b1; cond_ex = 1'b1; mcycle_op = MCYCLE_OP_MUL; operand1 = 32'd9; operand2 = 32'd9;
      @(posedge clk); #1; start = 1'b0;
      dc = 0;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         if (done) dc++;
      end
      $display("start during compute: done_pulses=%0d r1=%h r2=%h", dc, result1, result2);
      check("compute_start_done_count", 64'(dc), 64'd1);
      check("compute_start_result", {result2, result1}, 64'd42);

      // flush at COMPUTE cycle 10
      saved = {result2, result1};
      launch(MCYCLE_OP_MUL, 32'd3, 32'd5);
      repeat (9) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk);
      check("flush_busy_next", {63'd0, busy}, 64'd0);
      dc = 0;
      for (int c = 0; c < LAT + 5; c++) begin
         @(negedge clk);
         if (done) dc++;
      end
      $display("flush in compute: done_pulses=%0d r1=%h r2=%h", dc, result1, result2);
      check("flush_no_done", 64'(dc), 64'd0);
      check("flush_results_kept", {result2, result1}, saved);
      run_op(MCYCLE_OP_MUL, 32'd3, 32'd5, 64'd15);

      // reset at COMPUTE cycle 16
      launch(MCYCLE_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (15) @(posedge clk);
      #1; rst_n = 1'b0;
      #1;
      $display("reset mid-op: r1=%h r2=%h busy=%0d done=%0d", result1, result2, busy, done);
      check("midreset_results", {result2, result1}, 64'd0);
      check("midreset_busy_done", {62'd0, busy, done}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(MCYCLE_OP_MUL, 32'd6, 32'd7, 64'd42);

      // Random ops against the model, with frequent small and zero divisors
      for (int i = 0; i < 24; i++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 300));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
         run_op(rop, ra, rb, model(rop, ra, rb));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
